// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the RAM port arbiter.
//   arb_state_t  - access FSM states (IDLE -> ACCESS -> DONE -> IDLE)
//   MAX_REQ      - largest supported requester count
//   grant_bits() - width of a requester index for a given requester count
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  localparam int MAX_REQ = 8;

  // Index width for num_req requesters; never narrower than one bit.
  function automatic int grant_bits(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection for the RAM port arbiter.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins, ptr ignored); otherwise round-robin starting after ptr.
// Ports:
//   req   in  NUM_REQ     request vector
//   ptr   in  GRANT_BITS  index of the most recently served requester
//   grant out NUM_REQ     one-hot winner (all zero when no request)
//   valid out 1           at least one request present
module ram_arb_pick
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int GRANT_BITS = grant_bits(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]    req,
  input  logic [GRANT_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]    grant,
  output logic                  valid
);

  assign valid = |req;

`ifdef RAM_ARB_FIXED_PRIO_EN

  // Isolate the lowest set bit.
  assign grant = req & (~req + NUM_REQ'(1));

  logic unused_ptr;
  assign unused_ptr = ^ptr;

`else

  // Distance of requester j from the search start (ptr+1); 0 is served first.
  function automatic int rr_dist(input int j, input logic [GRANT_BITS-1:0] p);
    return (j + 2 * NUM_REQ - int'(p) - 1) % NUM_REQ;
  endfunction

  always_comb begin
    int best;
    // NOTE: every combinational output gets a default before any branch,
    // otherwise unassigned paths infer latches.
    best  = NUM_REQ;
    grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (req[j] && rr_dist(j, ptr) < best) best = rr_dist(j, ptr);
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      grant[j] = req[j] && (rr_dist(j, ptr) == best);
    end
  end

`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one RAM port between NUM_REQ requesters with a
// req/ack handshake. Each access takes IDLE (pick) -> ACCESS (drive RAM) ->
// DONE (ack + read data), hiding the RAM's 1-cycle registered read latency.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority and removes the
// round-robin pointer; default is round-robin.
// Ports:
//   in_clk, in_rst            clock, async active-high reset
//   in_req/in_write           per-requester request level and direction
//   in_addr/in_data           packed per-requester address / write data
//   out_ack                   one-hot completion strobe (DONE cycle)
//   out_data/out_err          read data and out-of-range flag, valid with ack
//   out_ram_*                 RAM port controls, in_ram_data RAM read data
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_BITS = 3,
  parameter int WORD_BITS = 8,
  parameter int NUM_WORDS = 2 ** ADDR_BITS,
  parameter int NUM_REQ   = 3
) (
  input  logic                           in_clk,
  input  logic                           in_rst,
  input  logic [NUM_REQ-1:0]             in_req,
  input  logic [NUM_REQ-1:0]             in_write,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   in_addr,
  input  logic [NUM_REQ*WORD_BITS-1:0]   in_data,
  output logic [NUM_REQ-1:0]             out_ack,
  output logic [WORD_BITS-1:0]           out_data,
  output logic                           out_err,
  output logic                           out_ram_read_ena,
  output logic                           out_ram_write_ena,
  output logic [ADDR_BITS-1:0]           out_ram_addr,
  output logic [WORD_BITS-1:0]           out_ram_data,
  input  logic [WORD_BITS-1:0]           in_ram_data
);

  localparam int GRANT_BITS = grant_bits(NUM_REQ);

  arb_state_t              state, state_nxt;
  logic [GRANT_BITS-1:0]   grant_q;
  logic                    lat_write;
  logic [ADDR_BITS-1:0]    lat_addr;
  logic [WORD_BITS-1:0]    lat_data;
  logic                    addr_oor;

  logic [NUM_REQ-1:0]      pick_onehot;
  logic                    pick_valid;
  logic [GRANT_BITS-1:0]   pick_idx;
  logic                    sel_write;
  logic [ADDR_BITS-1:0]    sel_addr;
  logic [WORD_BITS-1:0]    sel_data;
  logic [GRANT_BITS-1:0]   ptr;

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [GRANT_BITS-1:0]   rr_ptr_q;

  // Pointer starts at the last requester so requester 0 wins first.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) rr_ptr_q <= GRANT_BITS'(NUM_REQ - 1);
    else if (state == DONE) rr_ptr_q <= grant_q;
  end

  assign ptr = rr_ptr_q;
`endif

  ram_arb_pick #(
    .NUM_REQ    (NUM_REQ),
    .GRANT_BITS (GRANT_BITS)
  ) u_pick (
    .req   (in_req),
    .ptr   (ptr),
    .grant (pick_onehot),
    .valid (pick_valid)
  );

  // One-hot winner to index, and mux out the winner's transaction.
  always_comb begin
    pick_idx  = '0;
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        pick_idx  = GRANT_BITS'(i);
        sel_write = in_write[i];
        sel_addr  = in_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_data  = in_data[i*WORD_BITS +: WORD_BITS];
      end
    end
  end

  // The transaction is latched on grant, so a requester dropping req early
  // cannot disturb the access already in flight.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state     <= IDLE;
      grant_q   <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_valid) begin
        grant_q   <= pick_idx;
        lat_write <= sel_write;
        lat_addr  <= sel_addr;
        lat_data  <= sel_data;
      end
    end
  end

  // lat_addr is frozen from ACCESS through DONE, so the range flag derived
  // from it is stable for both the enable gating and the reported error.
  assign addr_oor = int'(lat_addr) >= NUM_WORDS;

  // RAM pins hold their last value outside ACCESS.
  assign out_ram_addr = lat_addr;
  assign out_ram_data = lat_data;

  always_comb begin
    state_nxt         = state;
    out_ack           = '0;
    out_data          = '0;
    out_err           = 1'b0;
    out_ram_read_ena  = 1'b0;
    out_ram_write_ena = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (!addr_oor) begin
          out_ram_read_ena  = !lat_write;
          out_ram_write_ena = lat_write;
        end
        state_nxt = DONE;
      end
      DONE: begin
        out_ack[grant_q] = 1'b1;
        out_err          = addr_oor;
        // RAM read data registered at the end of ACCESS is valid now.
        if (!lat_write && !addr_oor) out_data = in_ram_data;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
